// File: rtl/lap_record_buffer.sv
// Lap-time store: captures BCD stopwatch time on record presses, lets the user
// browse stored laps, and drives either live time or the selected lap out.
module lap_record_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk_core,
    input  logic             rst,
    input  logic             record,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             clear_i,
    input  logic             display_switch,
    input  logic [7:0]       min_i,
    input  logic [7:0]       sec_i,
    input  logic [7:0]       ms_10_i,
    output logic [7:0]       min_o,
    output logic [7:0]       sec_o,
    output logic [7:0]       ms_10_o,
    output logic [PTR_W:0]   count_o,
    output logic [PTR_W-1:0] view_idx_o,
    output logic             full_o
);

    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic             rec_prev_q, up_prev_q, dn_prev_q, clr_prev_q;
    logic             rec_ev, up_ev, dn_ev, clr_ev;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] view_q, view_d;
    logic             full;
    logic             mem_we;
    logic [23:0]      mem_q [DEPTH];
    logic [23:0]      disp_q, disp_d;

    assign rec_ev = record  & ~rec_prev_q;
    assign up_ev  = up_i    & ~up_prev_q;
    assign dn_ev  = down_i  & ~dn_prev_q;
    assign clr_ev = clear_i & ~clr_prev_q;

    assign full   = (count_q == DEPTH_C);
    assign mem_we = rec_ev & ~clr_ev & ~full;

    // Priority: clear, then record, then browse. A dropped record still
    // blocks browsing in the same cycle.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        view_d   = view_q;
        if (clr_ev) begin
            count_d  = '0;
            wr_ptr_d = '0;
            view_d   = '0;
        end else if (rec_ev) begin
            if (!full) begin
                count_d  = count_q + CNT_ONE;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                view_d   = wr_ptr_q;
            end
        end else if (count_q != '0) begin
            if (up_ev && !dn_ev) begin
                if (({1'b0, view_q} + CNT_ONE) < count_q)
                    view_d = view_q + PTR_ONE;
            end else if (dn_ev && !up_ev) begin
                if (view_q != '0)
                    view_d = view_q - PTR_ONE;
            end
        end
    end

    always_comb begin
        disp_d = {min_i, sec_i, ms_10_i};
        if (display_switch) begin
            if (count_q != '0)
                disp_d = mem_q[view_q];
            else
                disp_d = '0;
        end
    end

    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            rec_prev_q <= 1'b0;
            up_prev_q  <= 1'b0;
            dn_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            view_q     <= '0;
            disp_q     <= '0;
        end else begin
            rec_prev_q <= record;
            up_prev_q  <= up_i;
            dn_prev_q  <= down_i;
            clr_prev_q <= clear_i;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            view_q     <= view_d;
            disp_q     <= disp_d;
        end
    end

    // Lap storage is deliberately left unreset.
    always_ff @(posedge clk_core) begin
        if (mem_we)
            mem_q[wr_ptr_q] <= {min_i, sec_i, ms_10_i};
    end

    assign min_o      = disp_q[23:16];
    assign sec_o      = disp_q[15:8];
    assign ms_10_o    = disp_q[7:0];
    assign count_o    = count_q;
    assign view_idx_o = view_q;
    assign full_o     = full;

endmodule

// File: tb/tb_lap_record_buffer.sv
// Self-checking bench for lap_record_buffer: a per-cycle vector table plus
// hand-written sequences for held buttons, overflow, latency and async reset.
module tb_lap_record_buffer;

    logic       clk_core = 1'b0;
    logic       rst;
    logic       record, up_i, down_i, clear_i, display_switch;
    logic [7:0] min_i, sec_i, ms_10_i;
    logic [7:0] min_o, sec_o, ms_10_o;
    logic [3:0] count_o;
    logic [2:0] view_idx_o;
    logic       full_o;

    int total = 0;
    int bad   = 0;

    lap_record_buffer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk_core       (clk_core),
        .rst            (rst),
        .record         (record),
        .up_i           (up_i),
        .down_i         (down_i),
        .clear_i        (clear_i),
        .display_switch (display_switch),
        .min_i          (min_i),
        .sec_i          (sec_i),
        .ms_10_i        (ms_10_i),
        .min_o          (min_o),
        .sec_o          (sec_o),
        .ms_10_o        (ms_10_o),
        .count_o        (count_o),
        .view_idx_o     (view_idx_o),
        .full_o         (full_o)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic        rec, up, dn, clr, sw;
        logic [23:0] live;
        logic [3:0]  cnt;
        logic [2:0]  view;
        logic        full;
        logic [23:0] out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rec, logic up, logic dn, logic clr, logic sw,
                                logic [23:0] live, logic [3:0] cnt, logic [2:0] view,
                                logic full, logic [23:0] out);
        vec_t v;
        v.rec = rec; v.up = up; v.dn = dn; v.clr = clr; v.sw = sw;
        v.live = live; v.cnt = cnt; v.view = view; v.full = full; v.out = out;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic drive(input logic rec, input logic up, input logic dn, input logic clr,
                         input logic sw, input logic [23:0] live);
        record = rec; up_i = up; down_i = dn; clear_i = clr; display_switch = sw;
        {min_i, sec_i, ms_10_i} = live;
    endtask

    function automatic logic [23:0] outv();
        return {min_o, sec_o, ms_10_o};
    endfunction

    localparam logic [23:0] A = 24'h012345;
    localparam logic [23:0] B = 24'h020000;
    localparam logic [23:0] C = 24'h031122;
    localparam logic [23:0] X = 24'h095999;

    initial begin
        logic [23:0] t;
        int          k;

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, A);
        tick();
        tick();
        chk("reset_out", {8'h0, outv()}, 32'h0);
        chk("reset_cnt", {28'h0, count_o}, 32'h0);
        chk("reset_view", {29'h0, view_idx_o}, 32'h0);
        rst = 1'b1;

        //  rec up dn clr sw live  cnt view full out
        add(0, 0, 0, 0, 0, A, 0, 0, 0, A);
        add(1, 0, 0, 0, 0, A, 1, 0, 0, A);
        add(0, 0, 0, 0, 1, A, 1, 0, 0, A);
        add(0, 0, 0, 0, 1, X, 1, 0, 0, A);
        add(0, 0, 0, 0, 1, X, 1, 0, 0, A);
        add(1, 0, 0, 0, 1, B, 2, 1, 0, A);
        add(1, 0, 0, 0, 1, B, 2, 1, 0, B);
        add(0, 0, 0, 0, 1, X, 2, 1, 0, B);
        add(1, 0, 0, 0, 1, C, 3, 2, 0, B);
        add(0, 0, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 0, 1, 0, 1, X, 3, 1, 0, C);
        add(0, 0, 0, 0, 1, X, 3, 1, 0, B);
        add(0, 0, 1, 0, 1, X, 3, 0, 0, B);
        add(0, 0, 0, 0, 1, X, 3, 0, 0, A);
        add(0, 0, 1, 0, 1, X, 3, 0, 0, A);
        add(0, 0, 0, 0, 1, X, 3, 0, 0, A);
        add(0, 0, 1, 0, 1, X, 3, 0, 0, A);
        add(0, 0, 0, 0, 1, X, 3, 0, 0, A);
        add(0, 1, 0, 0, 1, X, 3, 1, 0, A);
        add(0, 0, 0, 0, 1, X, 3, 1, 0, B);
        add(0, 1, 0, 0, 1, X, 3, 2, 0, B);
        add(0, 0, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 1, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 0, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 1, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 0, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 1, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 0, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 1, 1, 0, 1, X, 3, 2, 0, C);
        add(0, 0, 0, 0, 1, X, 3, 2, 0, C);
        add(0, 0, 1, 0, 1, X, 3, 1, 0, C);
        add(0, 0, 0, 0, 1, X, 3, 1, 0, B);
        add(0, 1, 1, 0, 1, X, 3, 1, 0, B);
        add(0, 0, 0, 0, 1, X, 3, 1, 0, B);
        add(1, 0, 0, 1, 1, X, 0, 0, 0, B);
        add(0, 0, 0, 0, 1, X, 0, 0, 0, 24'h0);
        add(0, 1, 0, 0, 1, X, 0, 0, 0, 24'h0);
        add(0, 0, 0, 0, 1, X, 0, 0, 0, 24'h0);
        add(0, 0, 1, 0, 1, X, 0, 0, 0, 24'h0);
        add(0, 0, 0, 0, 1, X, 0, 0, 0, 24'h0);
        add(0, 0, 0, 0, 0, 24'h102030, 0, 0, 0, 24'h102030);
        add(0, 0, 0, 0, 0, 24'h112131, 0, 0, 0, 24'h112131);
        add(0, 0, 0, 0, 1, 24'h122232, 0, 0, 0, 24'h0);
        add(0, 0, 0, 0, 0, 24'h132333, 0, 0, 0, 24'h132333);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rec, vecs[i].up, vecs[i].dn, vecs[i].clr, vecs[i].sw, vecs[i].live);
            tick();
            chk($sformatf("vec%0d_cnt", i), {28'h0, count_o}, {28'h0, vecs[i].cnt});
            chk($sformatf("vec%0d_view", i), {29'h0, view_idx_o}, {29'h0, vecs[i].view});
            chk($sformatf("vec%0d_full", i), {31'h0, full_o}, {31'h0, vecs[i].full});
            chk($sformatf("vec%0d_out", i), {8'h0, outv()}, {8'h0, vecs[i].out});
        end

        // Held record for 20 cycles counts once.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 0, 0, 24'h040506);
            tick();
        end
        chk("held_rec_cnt", {28'h0, count_o}, 32'h1);
        drive(0, 0, 0, 0, 1, 24'h040506);
        tick();
        tick();
        chk("held_rec_recall", {8'h0, outv()}, 32'h040506);

        // Live path is registered: a mid-cycle input change is not visible yet.
        drive(0, 0, 0, 0, 0, 24'h200000);
        tick();
        chk("live_a", {8'h0, outv()}, 32'h200000);
        for (int i = 1; i < 5; i++) begin
            t = 24'h200000 + 24'(i);
            drive(0, 0, 0, 0, 0, t);
            #2;
            chk($sformatf("live_hold%0d", i), {8'h0, outv()}, {8'h0, t - 24'h1});
            tick();
            chk($sformatf("live_step%0d", i), {8'h0, outv()}, {8'h0, t});
        end

        // Fill to DEPTH and overflow by two presses.
        drive(0, 0, 0, 1, 0, 24'h0);
        tick();
        drive(0, 0, 0, 0, 0, 24'h0);
        tick();
        chk("fill_clear_cnt", {28'h0, count_o}, 32'h0);
        for (k = 0; k < 10; k++) begin
            t = {8'(k), 8'h30 + 8'(k), 8'h50 + 8'(k)};
            drive(1, 0, 0, 0, 0, t);
            tick();
            chk($sformatf("fill%0d_cnt", k), {28'h0, count_o}, (k < 8) ? k + 1 : 8);
            chk($sformatf("fill%0d_view", k), {29'h0, view_idx_o}, (k < 8) ? k : 7);
            chk($sformatf("fill%0d_full", k), {31'h0, full_o}, (k >= 7) ? 1 : 0);
            drive(0, 0, 0, 0, 0, t);
            tick();
        end
        drive(0, 0, 0, 0, 1, 24'h999999);
        tick();
        chk("fill_last_lap", {8'h0, outv()}, 32'h073757);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 0, 1, 24'h999999);
            tick();
            drive(0, 0, 0, 0, 1, 24'h999999);
            tick();
        end
        chk("fill_first_view", {29'h0, view_idx_o}, 32'h0);
        chk("fill_first_lap", {8'h0, outv()}, 32'h003050);

        // Async reset mid-cycle with record held, then release mid-press.
        drive(1, 0, 0, 0, 1, 24'h111111);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out", {8'h0, outv()}, 32'h0);
        chk("async_rst_cnt", {28'h0, count_o}, 32'h0);
        chk("async_rst_full", {31'h0, full_o}, 32'h0);
        chk("async_rst_view", {29'h0, view_idx_o}, 32'h0);
        #1;
        rst = 1'b1;
        tick();
        chk("rel_midpress_cnt", {28'h0, count_o}, 32'h1);
        chk("rel_midpress_view", {29'h0, view_idx_o}, 32'h0);
        drive(0, 0, 0, 0, 1, 24'h222222);
        tick();
        chk("rel_midpress_lap", {8'h0, outv()}, 32'h111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lap_record_buffer.md
# lap_record_buffer

Lap-time store between the stopwatch counter and the seven-segment driver. Captures the counter's BCD time (min/sec/10 ms) on each record-button press into a small on-chip buffer. Lets the user browse stored laps with up/down. Drives either the live time or the selected lap to the display stage, chosen by the display switch.

## Interface
Parameters:
- DEPTH, 8, number of lap slots; power of two, 2..16
- PTR_W, 3, log2(DEPTH)

Ports:
- clk_core  input  1  core clock, the divided clock shared with the debouncers and counter
- rst  input  1  asynchronous, active-low reset
- record  input  1  debounced record-button level
- up_i  input  1  debounced up-button level
- down_i  input  1  debounced down-button level
- clear_i  input  1  debounced clear level
- display_switch  input  1  0 = live time, 1 = recalled lap
- min_i  input  8  live minutes, 2-digit BCD
- sec_i  input  8  live seconds, 2-digit BCD
- ms_10_i  input  8  live hundredths, 2-digit BCD
- min_o  output  8  displayed minutes, BCD
- sec_o  output  8  displayed seconds, BCD
- ms_10_o  output  8  displayed hundredths, BCD
- count_o  output  PTR_W+1  number of stored laps, 0..DEPTH
- view_idx_o  output  PTR_W  index of the lap being viewed
- full_o  output  1  high when count_o == DEPTH

## Operation
- **Edge detection:** record, up_i, down_i and clear_i each have a prev register, reset to 0.
  - An event is asserted when the level is 1 and its prev register is 0.
  - Holding a button produces exactly one event.
- **Memory:** DEPTH x 24-bit register array holding {min, sec, ms_10}. Storage is raw; no BCD validation.
- **Event priority within one cycle:** clear > record > browse.
  - Up and down events in the same cycle cancel; view_idx is unchanged.
- **Clear:** count, wr_ptr and view_idx go to 0. Memory contents need not be erased.
- **Record:**
  - If count < DEPTH: write {min_i, sec_i, ms_10_i} to mem[wr_ptr], then wr_ptr+1, count+1, and view_idx <= old wr_ptr (the newest lap).
  - If full: the event is dropped and nothing changes.
- **Browse:** ignored when count == 0.
  - Up: view_idx+1 only if view_idx < count-1; otherwise it saturates.
  - Down: view_idx-1 only if view_idx > 0; otherwise it saturates.
  - No wrap-around in either direction.
- **Output mux** (registered):
  - display_switch=0: outputs take min_i, sec_i, ms_10_i.
  - display_switch=1 and count > 0: outputs take mem[view_idx].
  - display_switch=1 and count == 0: outputs are 8'h00 each.
- full_o, count_o and view_idx_o are driven directly from the state registers.
- **Reset** (rst=0, asynchronous): all of the following go to 0 immediately, regardless of clk_core:
  - prev registers, wr_ptr, count, view_idx;
  - min_o, sec_o, ms_10_o, full_o.
  - Memory need not reset.
- **Reset release mid-press:** a button already held when rst deasserts produces an event on the first clk_core edge, because its prev register is 0.

## Timing
- All state changes on the rising edge of clk_core.
- **Event sampling:** an event is recognised at edge k, the first edge at which the level is sampled 1. Its state update (memory write, count, view_idx) completes at edge k.
- **count_o, full_o, view_idx_o:** updated at edge k, the same edge as the event.
- **Live path:** min_o, sec_o, ms_10_o at edge k+1 reflect the inputs sampled at edge k (1-cycle latency).
- **Recall path:** outputs reflect a new view_idx or new memory contents at edge k+1.
- **display_switch change:** the output source changes at the next edge.
- **Record with simultaneous input change:** the value stored is min_i/sec_i/ms_10_i as sampled at edge k.
- No handshake. All inputs are treated as synchronous to clk_core, since they come from the debouncers on that clock.

## Test plan
- **Reset:** assert rst=0 mid-cycle.
  - Required: all outputs 0 asynchronously; count_o=0, view_idx_o=0.
- **Single record:** live 01:23.45, one record press, then display_switch=1.
  - Required: count_o=1, view_idx_o=0, outputs 8'h01/8'h23/8'h45.
  - Then change the live inputs. Required: recalled value unchanged.
- **Fill and overflow:** DEPTH+2 presses with distinct times.
  - Required: count_o=8, full_o=1; the 9th and 10th presses are ignored; view_idx_o=7.
  - mem[7] holds the 8th time.
- **Browse saturation:** with 3 laps stored, press down 4 times.
  - Required: view_idx_o=0, and lap 0 is shown.
  - Then press up 5 times. Required: view_idx_o=2.
  - Up and down in the same cycle. Required: no change.
- **Held button and priority:**
  - Hold record for 20 cycles. Required: count increments by 1.
  - Clear and record in the same cycle. Required: count_o=0.
  - Recall with count_o=0. Required: outputs 00/00/00.
- **Live latency:** display_switch=0, step the inputs each cycle.
  - Required: outputs equal the inputs delayed by exactly 1 cycle.
